// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared types and default constants for the push-button debouncer.
//
// Contents:
//   btn_state_t              debouncer FSM state encoding
//   CLK_HZ_DEFAULT           nominal board clock (50 MHz)
//   DEBOUNCE_CYCLES_DEFAULT  10 ms stability window at CLK_HZ_DEFAULT
//   LONG_CYCLES_DEFAULT      1 s long-press threshold at CLK_HZ_DEFAULT
//   cnt_width()              counter width able to hold 0 .. n-1, never 0
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ_DEFAULT          = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ_DEFAULT / 100;
    localparam int unsigned LONG_CYCLES_DEFAULT     = CLK_HZ_DEFAULT;

    // $clog2(n) holds 0..n-1; the guard keeps a degenerate n from giving a
    // zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous board input. Reusable for
// any slow level signal (buttons, switches, straps).
//
// Parameters:
//   RESET_VAL  value both flops take while rst_n is low
// Ports:
//   clk    input   destination clock, rising edge
//   rst_n  input   asynchronous assert, active-low reset
//   d      input   asynchronous input level
//   q      output  level synchronized to clk, 2 cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // meta_q may go metastable; only sync_q is allowed to fan out.
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Reads a bouncing board push-button: synchronizes it to clk, accepts a level
// change only after it has been stable for DEBOUNCE_CYCLES, and emits a clean
// pressed level plus one-cycle press / release / long-press pulses.
//
// Optional build macro:
//   BUTTON_DEBOUNCE_LONG_PRESS_EN  when defined, the hold counter and the
//                                  long_press pulse are built; otherwise
//                                  long_press is tied low (port retained).
//
// Parameters:
//   DEBOUNCE_CYCLES  stability window in clk cycles, >= 2
//   LONG_CYCLES      debounced hold time before long_press, > DEBOUNCE_CYCLES
//   ACTIVE_LOW       1 = pin reads 0 while pressed
// Ports:
//   clk            input   system clock, rising edge
//   rst_n          input   asynchronous assert, active-low reset
//   btn_raw        input   raw button pin (asynchronous, bouncing)
//   btn_level      output  debounced pressed state, 1 = pressed
//   press          output  one-cycle pulse when a press is accepted
//   release_pulse  output  one-cycle pulse when a release is accepted
//                          ("release" itself is a reserved word)
//   long_press     output  one-cycle pulse, at most once per press
//
// Timing: press and release_pulse rise 2 + DEBOUNCE_CYCLES clocks after the
// first edge that samples the new stable pin level.
// ----------------------------------------------------------------------------
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT,
    parameter logic        ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the parameter relationships.
    if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_param_check
        $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    // ------------------------------------------------------------------
    // Input path: normalise polarity before synchronizing so the reset
    // value "not pressed" is always 0 regardless of pin polarity.
    // ------------------------------------------------------------------
    logic btn_in;
    logic btn_s;

    assign btn_in = btn_raw ^ ACTIVE_LOW;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM. cnt measures how long btn_s has held the candidate
    // level; any sample back at the accepted level restarts the window.
    // ------------------------------------------------------------------
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (btn_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce: abandon the window without any pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (!btn_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    // ------------------------------------------------------------------
    // Long press. hold_cnt counts stable PRESSED cycles and saturates at
    // LONG_CYCLES-1; the pulse fires on the PRESSED cycle that observes
    // the saturated value. long_armed_q limits it to once per accepted
    // press: a bounce through RELEASE_WAIT returns to PRESSED without
    // re-arming, only a fresh press does.
    // ------------------------------------------------------------------
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_armed_q, long_armed_d;
    logic              long_press_q, long_press_d;

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        long_armed_d = long_armed_q;
        long_press_d = 1'b0;

        if (press_d) begin
            hold_cnt_d   = '0;
            long_armed_d = 1'b1;
        end else if (state_q == PRESSED) begin
            if (long_armed_q && (hold_cnt_q == HOLD_LAST)) begin
                long_press_d = 1'b1;
                long_armed_d = 1'b0;
            end
            if (btn_s && (hold_cnt_q != HOLD_LAST)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q   <= '0;
            long_armed_q <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            long_armed_q <= long_armed_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule
